pong_vga_timing: RTL
====================

Name: pong_vga_timing

Overview:
- Generates the pixel-interface timing that drives pong_pixel_engine:
  - horizontal counter;
  - next-line vertical count;
  - horizontal blanking flag;
  - once-per-frame strobe.
- Consumes the engine's RGB and delays HSYNC/VSYNC/active to match the engine pipeline.
- Drives the registered, blanked VGA pins.
- Sits between the top-level pad ring and the pixel engine.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- H_CNT_WID, 10, width of the H counter (must hold H_TOTAL-1)
- V_CNT_WID, 10, width of the V counter (must hold V_TOTAL-1)
- PIPELINE_STAGES, 1, pixel-engine latency in clocks; 0 allowed
- SYNC_ACTIVE_LOW, 1, 1 = syncs asserted low, 0 = asserted high

Ports:
- pixIf_CLK  in  1  pixel clock
- rst_n  in  1  reset, asynchronous, active-low
- pixIf_H_CNT  out  H_CNT_WID  current horizontal count, 0..H_TOTAL-1
- pixIf_next_V_CNT  out  V_CNT_WID  line index following the current line
- pixIf_H_BLANKING  out  1  high when pixIf_H_CNT >= H_ACTIVE
- pixIf_NEXT_FRAME  out  1  one-clock strobe at the start of vertical blanking
- pix_r / pix_g / pix_b  in  4 each  colour from the pixel engine, PIPELINE_STAGES behind pixIf_H_CNT
- vga_hsync, vga_vsync  out  1 each  registered sync pins
- vga_r / vga_g / vga_b  out  4 each  registered colour pins

Behaviour:
- Totals:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
  - V_TOTAL likewise from the V parameters.
- h_cnt and v_cnt are registers.
- h_cnt increments every clock and wraps H_TOTAL-1 -> 0.
- v_cnt increments only on the h_cnt wrap, and wraps V_TOTAL-1 -> 0 on the same clock as h_cnt.
- pixIf_H_CNT = h_cnt, with no added latency.
- pixIf_next_V_CNT = 0 if v_cnt == V_TOTAL-1, else v_cnt+1. It is stable for the entire line.
- pixIf_NEXT_FRAME = 1 exactly when h_cnt == 0 and v_cnt == V_ACTIVE, i.e. one pulse per frame.
- Raw timing signals, combinational from the counters:
  - active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE)
  - hs = H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC
  - vs = V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC
- active/hs/vs pass through a PIPELINE_STAGES-deep shift register so they align with pix_*. With PIPELINE_STAGES = 0 they are direct wires.
- Output register, every clock:
  - vga_r/g/b = delayed active ? pix_* : 0
  - vga_hsync = delayed hs XOR SYNC_ACTIVE_LOW; vga_vsync likewise.
- Total latency from a counter value to its pins is PIPELINE_STAGES+1 clocks.
- Reset (asynchronous):
  - h_cnt = v_cnt = 0; delay line cleared.
  - vga_r/g/b = 0.
  - Syncs at their deasserted level (1 when SYNC_ACTIVE_LOW = 1).
  - pixIf_NEXT_FRAME = 0 during reset and for the first frame until v_cnt reaches V_ACTIVE.
- Reset mid-frame restarts at pixel (0,0). No partial sync pulse is extended; the delay line is flushed.
- Colour during blanking is forced to 0 irrespective of pix_*.

Optional Feature:
- Macro PONG_VGA_TEST_PATTERN_EN.
- Defined:
  - Adds input port test_pattern (1 bit).
  - When test_pattern = 1, the pixel engine colour is replaced by 8 vertical colour bars: bar index = delayed h_cnt[8:6], bit0 -> R=F, bit1 -> G=F, bit2 -> B=F.
  - The bars are still blanked outside the active area.
  - The h_cnt delay line is added only under this macro.
- Undefined: the port is absent and behaviour is exactly as above.

Decomposition:
- Package pong_vga_pkg holds:
  - default 640x480@60 timing constants;
  - function-derived H_TOTAL/V_TOTAL;
  - the SYNC_ACTIVE_LOW default.
- One sub-module, pong_delay_line (parameters WIDTH, DEPTH; DEPTH = 0 gives a pass-through), used for active/hs/vs and, under the macro, h_cnt.

Test Plan:
- Release reset, defaults -> pixIf_H_CNT counts 0..799 and wraps. pixIf_H_BLANKING rises at 640 and falls at 0. pixIf_next_V_CNT steps once per 800 clocks.
- Run 2 frames -> pixIf_NEXT_FRAME is high exactly once per 420000 clocks, at h=0, v=480. pixIf_next_V_CNT shows 0 throughout line 524.
- PIPELINE_STAGES = 1 -> vga_hsync is low for 96 clocks, starting 2 clocks after h_cnt = 656. vga_vsync is low for lines 490-491, with the same 2-clock skew.
- Drive pix_* = 4'hA constant -> vga_r = A for 640 clocks per active line (2-clock offset) and 0 elsewhere, including lines 480-524.
- Assert rst_n low at h=300, v=200 for 3 clocks -> outputs immediately rgb = 0, syncs = 1. After release, h_cnt restarts at 0 and v_cnt restarts at 0.
- With PONG_VGA_TEST_PATTERN_EN and test_pattern = 1 -> pixels 64-127 show R=F,G=0,B=0 and pixels 448-511 show R=F,G=F,B=B=F, each with a 2-clock offset.

Source files
------------

// File: rtl/pong_vga_pkg.sv
// pong_vga_pkg -- shared timing constants for the pong VGA pixel interface.
//   Default 640x480@60 timing (25.175 MHz pixel clock), the line/frame total
//   helper and the default sync polarity.
package pong_vga_pkg;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;

    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    localparam int unsigned DEF_SYNC_ACTIVE_LOW = 1;

    // Total clocks per line (or lines per frame) from the four timing regions.
    function automatic int unsigned timing_total(
        input int unsigned active,
        input int unsigned fp,
        input int unsigned sync,
        input int unsigned bp
    );
        return active + fp + sync + bp;
    endfunction

    localparam int unsigned DEF_H_TOTAL =
        timing_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int unsigned DEF_V_TOTAL =
        timing_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/pong_delay_line.sv
// pong_delay_line -- DEPTH-stage register delay with asynchronous clear.
//   clk   : in   clock
//   rst_n : in   asynchronous active-low reset, clears every stage
//   d     : in   WIDTH-bit input
//   q     : out  d delayed by DEPTH clocks (DEPTH = 0 is a plain wire)
module pong_delay_line #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign q = d;
        end else begin : g_reg
            logic [WIDTH-1:0] stage_q [DEPTH];
            logic [WIDTH-1:0] stage_d [DEPTH];

            always_comb begin
                stage_d[0] = d;
                for (int unsigned i = 1; i < DEPTH; i++) begin
                    stage_d[i] = stage_q[i-1];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int unsigned i = 0; i < DEPTH; i++) begin
                        stage_q[i] <= '0;
                    end
                end else begin
                    stage_q <= stage_d;
                end
            end

            assign q = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/pong_vga_timing.sv
// pong_vga_timing -- pixel-interface timing generator and VGA pin driver.
//   pixIf_CLK        : in   pixel clock
//   rst_n            : in   asynchronous active-low reset
//   test_pattern     : in   colour-bar override (only with PONG_VGA_TEST_PATTERN_EN)
//   pixIf_H_CNT      : out  current horizontal count, 0..H_TOTAL-1
//   pixIf_next_V_CNT : out  line index following the current line
//   pixIf_H_BLANKING : out  high while pixIf_H_CNT >= H_ACTIVE
//   pixIf_NEXT_FRAME : out  one-clock strobe at (h=0, v=V_ACTIVE)
//   pix_r/g/b        : in   engine colour, PIPELINE_STAGES behind pixIf_H_CNT
//   vga_hsync/vsync  : out  registered sync pins
//   vga_r/g/b        : out  registered, blanked colour pins
// Optional build macro: PONG_VGA_TEST_PATTERN_EN adds the test_pattern input
// and replaces engine colour with 8 vertical bars while it is high.
module pong_vga_timing
    import pong_vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE        = DEF_H_ACTIVE,
    parameter int unsigned H_FP            = DEF_H_FP,
    parameter int unsigned H_SYNC          = DEF_H_SYNC,
    parameter int unsigned H_BP            = DEF_H_BP,
    parameter int unsigned V_ACTIVE        = DEF_V_ACTIVE,
    parameter int unsigned V_FP            = DEF_V_FP,
    parameter int unsigned V_SYNC          = DEF_V_SYNC,
    parameter int unsigned V_BP            = DEF_V_BP,
    parameter int unsigned H_CNT_WID       = 10,
    parameter int unsigned V_CNT_WID       = 10,
    parameter int unsigned PIPELINE_STAGES = 1,
    parameter int unsigned SYNC_ACTIVE_LOW = DEF_SYNC_ACTIVE_LOW
) (
    input  logic                 pixIf_CLK,
    input  logic                 rst_n,
`ifdef PONG_VGA_TEST_PATTERN_EN
    input  logic                 test_pattern,
`endif
    output logic [H_CNT_WID-1:0] pixIf_H_CNT,
    output logic [V_CNT_WID-1:0] pixIf_next_V_CNT,
    output logic                 pixIf_H_BLANKING,
    output logic                 pixIf_NEXT_FRAME,
    input  logic [3:0]           pix_r,
    input  logic [3:0]           pix_g,
    input  logic [3:0]           pix_b,
    output logic                 vga_hsync,
    output logic                 vga_vsync,
    output logic [3:0]           vga_r,
    output logic [3:0]           vga_g,
    output logic [3:0]           vga_b
);

    localparam int unsigned H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [H_CNT_WID-1:0] H_LAST   = H_CNT_WID'(H_TOTAL - 1);
    localparam logic [H_CNT_WID-1:0] H_ACT_C  = H_CNT_WID'(H_ACTIVE);
    localparam logic [H_CNT_WID-1:0] HS_START = H_CNT_WID'(H_ACTIVE + H_FP);
    localparam logic [H_CNT_WID-1:0] HS_END   = H_CNT_WID'(H_ACTIVE + H_FP + H_SYNC);

    localparam logic [V_CNT_WID-1:0] V_LAST   = V_CNT_WID'(V_TOTAL - 1);
    localparam logic [V_CNT_WID-1:0] V_ACT_C  = V_CNT_WID'(V_ACTIVE);
    localparam logic [V_CNT_WID-1:0] VS_START = V_CNT_WID'(V_ACTIVE + V_FP);
    localparam logic [V_CNT_WID-1:0] VS_END   = V_CNT_WID'(V_ACTIVE + V_FP + V_SYNC);

    // Pin level for a deasserted sync; XOR with the raw sync gives the pin.
    localparam logic SYNC_IDLE = (SYNC_ACTIVE_LOW != 0);

    logic [H_CNT_WID-1:0] h_cnt_q, h_cnt_d;
    logic [V_CNT_WID-1:0] v_cnt_q, v_cnt_d;
    logic                 h_wrap, v_last;

    logic active_raw, hs_raw, vs_raw;
    logic active_dly, hs_dly, vs_dly;

    logic [3:0] src_r, src_g, src_b;
    logic [3:0] vga_r_q, vga_r_d;
    logic [3:0] vga_g_q, vga_g_d;
    logic [3:0] vga_b_q, vga_b_d;
    logic       vga_hsync_q, vga_hsync_d;
    logic       vga_vsync_q, vga_vsync_d;

    // ---------------- counters ----------------
    assign h_wrap = (h_cnt_q == H_LAST);
    assign v_last = (v_cnt_q == V_LAST);

    always_comb begin
        h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (h_wrap) begin
            v_cnt_d = v_last ? '0 : v_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge pixIf_CLK or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // ---------------- pixel interface ----------------
    assign pixIf_H_CNT      = h_cnt_q;
    assign pixIf_next_V_CNT = v_last ? '0 : v_cnt_q + 1'b1;
    assign pixIf_H_BLANKING = (h_cnt_q >= H_ACT_C);
    assign pixIf_NEXT_FRAME = (h_cnt_q == '0) && (v_cnt_q == V_ACT_C);

    // ---------------- raw timing and alignment ----------------
    assign active_raw = (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
    assign hs_raw     = (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
    assign vs_raw     = (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);

    pong_delay_line #(
        .WIDTH (3),
        .DEPTH (PIPELINE_STAGES)
    ) u_timing_dly (
        .clk   (pixIf_CLK),
        .rst_n (rst_n),
        .d     ({active_raw, hs_raw, vs_raw}),
        .q     ({active_dly, hs_dly, vs_dly})
    );

    // ---------------- colour source ----------------
`ifdef PONG_VGA_TEST_PATTERN_EN
    logic [2:0] bar_dly;

    // Only h_cnt[8:6] selects a bar, so only those bits are delayed.
    pong_delay_line #(
        .WIDTH (3),
        .DEPTH (PIPELINE_STAGES)
    ) u_hcnt_dly (
        .clk   (pixIf_CLK),
        .rst_n (rst_n),
        .d     (h_cnt_q[8:6]),
        .q     (bar_dly)
    );

    always_comb begin
        src_r = pix_r;
        src_g = pix_g;
        src_b = pix_b;
        if (test_pattern) begin
            src_r = {4{bar_dly[0]}};
            src_g = {4{bar_dly[1]}};
            src_b = {4{bar_dly[2]}};
        end
    end
`else
    always_comb begin
        src_r = pix_r;
        src_g = pix_g;
        src_b = pix_b;
    end
`endif

    // ---------------- output register ----------------
    always_comb begin
        vga_r_d     = active_dly ? src_r : '0;
        vga_g_d     = active_dly ? src_g : '0;
        vga_b_d     = active_dly ? src_b : '0;
        vga_hsync_d = hs_dly ^ SYNC_IDLE;
        vga_vsync_d = vs_dly ^ SYNC_IDLE;
    end

    always_ff @(posedge pixIf_CLK or negedge rst_n) begin
        if (!rst_n) begin
            vga_r_q     <= '0;
            vga_g_q     <= '0;
            vga_b_q     <= '0;
            vga_hsync_q <= SYNC_IDLE;
            vga_vsync_q <= SYNC_IDLE;
        end else begin
            vga_r_q     <= vga_r_d;
            vga_g_q     <= vga_g_d;
            vga_b_q     <= vga_b_d;
            vga_hsync_q <= vga_hsync_d;
            vga_vsync_q <= vga_vsync_d;
        end
    end

    assign vga_r     = vga_r_q;
    assign vga_g     = vga_g_q;
    assign vga_b     = vga_b_q;
    assign vga_hsync = vga_hsync_q;
    assign vga_vsync = vga_vsync_q;

endmodule
